aht10_i2c_byte_engine: RTL and testbench

//  Byte-level I2C master PHY directly downstream of the AHT10 read/write controller.
//  - Executes one req/cmd/wr_data transaction: optional START, one WRITE or READ byte with ACK slot, optional STOP.
//  - Returns rd_data plus a one-cycle done pulse.
//  - Drives SCL and open-drain SDA toward the sensor; the top level builds the inout pad.

---
 rtl/aht10_i2c_byte_engine_pkg.sv | 32 +++
 rtl/aht10_i2c_byte_engine_i2c_phase_gen.sv | 48 ++++
 rtl/aht10_i2c_byte_engine.sv | 136 +++++++++++++
 tb/tb_aht10_i2c_byte_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aht10_i2c_byte_engine_pkg.sv
// Shared commands, bus constants and state encoding for the AHT10 I2C byte engine.
package aht10_i2c_byte_engine_pkg;

   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_WRITE = 4'b0010;
   localparam logic [3:0] CMD_READ  = 4'b0100;
   localparam logic [3:0] CMD_STOP  = 4'b1000;

   localparam logic [6:0] I2C_ADR = 7'h38;
   localparam logic       WR_BIT  = 1'b0;
   localparam logic       RD_BIT  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WRITE = 3'd2,
      ST_RACK  = 3'd3,
      ST_READ  = 3'd4,
      ST_SACK  = 3'd5,
      ST_STOP  = 3'd6,
      ST_DONE  = 3'd7
   } state_e;

   // Segment that follows START (or IDLE when START is absent): WRITE > READ > STOP > DONE.
   function automatic state_e next_after_start(input logic [3:0] cmd);
      if (cmd[1]) return ST_WRITE;
      if (cmd[2]) return ST_READ;
      if (cmd[3]) return ST_STOP;
      return ST_DONE;
   endfunction

endpackage

// File: rtl/aht10_i2c_byte_engine_i2c_phase_gen.sv
// Quarter-period divider and 4-phase counter; q_end_o marks the last clock of each quarter.
// Both counters restart from zero whenever clr_i is high and freeze while en_i is low.
module i2c_phase_gen #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int SCL_FREQ = 100_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       clr_i,
   output logic [1:0] phase_o,
   output logic       q_end_o
);

   localparam int Q  = CLK_FREQ / (4 * SCL_FREQ);
   localparam int QW = (Q > 1) ? $clog2(Q) : 1;

   logic [QW-1:0] q_cnt_q, q_cnt_d;
   logic [1:0]    phase_q, phase_d;

   assign q_end_o = en_i && (q_cnt_q == QW'(Q - 1));
   assign phase_o = phase_q;

   always_comb begin
      q_cnt_d = q_cnt_q;
      phase_d = phase_q;
      if (clr_i) begin
         q_cnt_d = '0;
         phase_d = 2'd0;
      end else if (q_end_o) begin
         q_cnt_d = '0;
         phase_d = phase_q + 2'd1;
      end else if (en_i) begin
         q_cnt_d = q_cnt_q + QW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_cnt_q <= '0;
         phase_q <= 2'd0;
      end else begin
         q_cnt_q <= q_cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/aht10_i2c_byte_engine.sv
// Byte-level I2C master: optional START, one WRITE or READ byte with ACK slot, optional STOP.
// done_o pulses 1+Q*N cycles after accept; req_i is only looked at in IDLE.
module aht10_i2c_byte_engine
   import aht10_i2c_byte_engine_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int SCL_FREQ = 100_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_i,
   input  logic [3:0] cmd_i,
   input  logic [7:0] wr_data_i,
   output logic [7:0] rd_data_o,
   output logic       done_o,
   output logic       ack_err_o,
   output logic       scl_o,
   output logic       sda_out_o,
   output logic       sda_oe_o,
   input  logic       sda_in_i
);

   state_e     state_q, state_d;
   logic [1:0] phase;
   logic       q_end, seg_end, sample, in_bus, clr, bit_scl, sda_s;
   logic [2:0] bit_q, bit_d;
   logic [3:0] cmd_q;
   logic [7:0] wr_q, sh_q, rd_q;
   logic       ack_err_q;
   logic [1:0] sync_q;
   logic       scl_hold_q, oe_hold_q, scl_c, oe_c;

   assign in_bus  = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign clr     = (state_d != state_q);
   assign seg_end = q_end && (phase == 2'd3);
   assign sample  = q_end && (phase == 2'd1);
   assign bit_scl = (phase == 2'd1) || (phase == 2'd2);
   assign sda_s   = sync_q[1];
   assign bit_d   = clr ? 3'd0 : (seg_end ? bit_q + 3'd1 : bit_q);

   i2c_phase_gen #(
      .CLK_FREQ (CLK_FREQ),
      .SCL_FREQ (SCL_FREQ)
   ) u_phase_gen (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (in_bus),
      .clr_i   (clr),
      .phase_o (phase),
      .q_end_o (q_end)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_i) state_d = cmd_i[0] ? ST_START : next_after_start(cmd_i);
         ST_START: if (seg_end) state_d = next_after_start(cmd_q);
         ST_WRITE: if (seg_end && bit_q == 3'd7) state_d = ST_RACK;
         ST_READ:  if (seg_end && bit_q == 3'd7) state_d = ST_SACK;
         ST_RACK,
         ST_SACK:  if (seg_end) state_d = cmd_q[3] ? ST_STOP : ST_DONE;
         ST_STOP:  if (seg_end) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outside bus segments the lines keep their last level, so back-to-back bytes hold SCL low.
   always_comb begin
      scl_c = scl_hold_q;
      oe_c  = oe_hold_q;
      case (state_q)
         ST_START: begin
            scl_c = (phase == 2'd0) ? scl_hold_q : (phase != 2'd3);
            oe_c  = phase[1];
         end
         ST_WRITE: begin
            scl_c = bit_scl;
            oe_c  = ~wr_q[3'd7 - bit_q];
         end
         ST_RACK, ST_READ: begin
            scl_c = bit_scl;
            oe_c  = 1'b0;
         end
         ST_SACK: begin
            scl_c = bit_scl;
            oe_c  = ~cmd_q[3];
         end
         ST_STOP: begin
            scl_c = (phase != 2'd0);
            oe_c  = ~phase[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_q      <= 3'd0;
         cmd_q      <= 4'd0;
         wr_q       <= 8'd0;
         sh_q       <= 8'd0;
         rd_q       <= 8'd0;
         ack_err_q  <= 1'b0;
         sync_q     <= 2'b11;
         scl_hold_q <= 1'b1;
         oe_hold_q  <= 1'b0;
      end else begin
         bit_q      <= bit_d;
         sync_q     <= {sync_q[0], sda_in_i};
         scl_hold_q <= scl_c;
         oe_hold_q  <= oe_c;
         if (state_q == ST_IDLE && req_i) begin
            cmd_q     <= cmd_i;
            wr_q      <= wr_data_i;
            ack_err_q <= 1'b0;
         end
         if (state_q == ST_RACK && sample && sda_s) ack_err_q <= 1'b1;
         if (state_q == ST_READ && sample) sh_q <= {sh_q[6:0], sda_s};
         if (state_q == ST_SACK && seg_end) rd_q <= sh_q;
      end
   end

   assign scl_o     = scl_c;
   assign sda_oe_o  = oe_c;
   assign sda_out_o = 1'b0;
   assign done_o    = (state_q == ST_DONE);
   assign rd_data_o = rd_q;
   assign ack_err_o = ack_err_q;

endmodule

// File: tb/tb_aht10_i2c_byte_engine.sv
// Bench for the AHT10 I2C byte engine: vector table, corner sequences and randomized transactions
// against a byte-level bus/slave model with pull-up.
module tb_aht10_i2c_byte_engine;

   localparam int CLK_FREQ = 800_000;
   localparam int SCL_FREQ = 100_000;
   localparam int Q        = CLK_FREQ / (4 * SCL_FREQ);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic [3:0] cmd = 4'd0;
   logic [7:0] wr  = 8'd0;
   logic [7:0] rd_data_o;
   logic       done_o, ack_err_o, scl_o, sda_out_o, sda_oe_o;
   logic       slave_drv = 1'b0;
   wire        sda_line = ~sda_oe_o & ~slave_drv;

   aht10_i2c_byte_engine #(
      .CLK_FREQ (CLK_FREQ),
      .SCL_FREQ (SCL_FREQ)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .cmd_i     (cmd),
      .wr_data_i (wr),
      .rd_data_o (rd_data_o),
      .done_o    (done_o),
      .ack_err_o (ack_err_o),
      .scl_o     (scl_o),
      .sda_out_o (sda_out_o),
      .sda_oe_o  (sda_oe_o),
      .sda_in_i  (sda_line)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Slave configuration (written by the stimulus only)
   logic       s_read = 1'b0;
   logic [7:0] s_rbyte = 8'd0;
   logic       s_ack = 1'b1;
   int         s_nbytes = 1;
   logic       s_pre_start = 1'b0;
   int         setup_seq = 0;

   // Bus observation (written by the monitor only)
   logic bits[$];
   int   seen_seq = 0;
   int   starts = 0, stops = 0, bus_changes = 0;
   logic prev_scl = 1'b1, prev_sda = 1'b1, prev_oe = 1'b0;

   // Slave level for the n-th SCL pulse after setup/START: 9 pulses per byte.
   function automatic logic slave_fn(input int n);
      int b = n / 9;
      int p = n % 9;
      if (b >= s_nbytes) return 1'b0;
      if (s_read) return (p < 8) ? ~s_rbyte[7-p] : 1'b0;
      return (p == 8) ? s_ack : 1'b0;
   endfunction

   always @(negedge clk) begin
      if (setup_seq != seen_seq) begin
         seen_seq = setup_seq;
         bits.delete();
         slave_drv = s_pre_start ? 1'b0 : slave_fn(0);
      end else begin
         if (scl_o && !prev_scl) bits.push_back(sda_line);
         else if (scl_o && prev_scl && prev_sda && !sda_line) begin
            starts++;
            bits.delete();
         end else if (scl_o && prev_scl && !prev_sda && sda_line) stops++;
         if (!scl_o && prev_scl) slave_drv = slave_fn(bits.size());
         if (scl_o !== prev_scl || sda_oe_o !== prev_oe) bus_changes++;
      end
      prev_scl = scl_o;
      prev_sda = ~sda_oe_o & ~slave_drv;
      prev_oe  = sda_oe_o;
   end

   task automatic slave_cfg(input logic rdm, input logic [7:0] sb, input logic ak,
                            input int nb, input logic pre);
      s_read = rdm; s_rbyte = sb; s_ack = ak; s_nbytes = nb; s_pre_start = pre;
      setup_seq++;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run_txn(input logic [3:0] c, input logic [7:0] wd, output int lat, output logic ae1);
      @(negedge clk);
      req = 1'b1; cmd = c; wr = wd;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      lat = 1;
      ae1 = ack_err_o;
      while (!done_o && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic [7:0] bits_byte();
      logic [7:0] b = 8'd0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits[i]};
      return b;
   endfunction

   task automatic check_bits(input string name, input logic [7:0] byte_exp, input logic b8_exp);
      check({name, "_nbits"}, 32'(bits.size() >= 9), 32'd1);
      if (bits.size() >= 9) begin
         check({name, "_byte"}, 32'(bits_byte()), 32'(byte_exp));
         check({name, "_ackbit"}, 32'(bits[8]), 32'(b8_exp));
      end
   endtask

   typedef struct {
      logic [3:0] cmd;
      logic [7:0] wd;
      logic [7:0] sbyte;
      logic       sack;
      int         lat;
      logic       ae;
      logic [7:0] rd;
      logic       chk_bits;
      logic [7:0] bbyte;
      logic       b8;
   } vec_t;

   vec_t tbl[7];
   int   b2b_lat[4]      = '{81, 74, 74, 82};
   logic [3:0] b2b_cmd[4] = '{4'b0011, 4'b0010, 4'b0010, 4'b1010};
   logic [7:0] b2b_wd[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, st0, sp0, bc0;
      logic ae1;
      logic [7:0] rd_model;

      tbl[0] = '{4'b0011, 8'h70, 8'h00, 1'b1, 81, 1'b0, 8'h00, 1'b1, 8'h70, 1'b0};
      tbl[1] = '{4'b1100, 8'h00, 8'h1C, 1'b0, 81, 1'b0, 8'h1C, 1'b1, 8'h1C, 1'b1};
      tbl[2] = '{4'b0010, 8'h5A, 8'h00, 1'b0, 73, 1'b1, 8'h1C, 1'b1, 8'h5A, 1'b1};
      tbl[3] = '{4'b0101, 8'h00, 8'hC3, 1'b0, 81, 1'b0, 8'hC3, 1'b1, 8'hC3, 1'b0};
      tbl[4] = '{4'b1011, 8'h81, 8'h00, 1'b1, 89, 1'b0, 8'hC3, 1'b1, 8'h81, 1'b0};
      tbl[5] = '{4'b1000, 8'h00, 8'h00, 1'b0,  9, 1'b0, 8'hC3, 1'b0, 8'h00, 1'b0};
      tbl[6] = '{4'b0111, 8'h3C, 8'hFF, 1'b1, 81, 1'b0, 8'hC3, 1'b1, 8'h3C, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_scl", 32'(scl_o), 32'd1);
      check("rst_oe", 32'(sda_oe_o), 32'd0);
      check("rst_sda_out", 32'(sda_out_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_rd", 32'(rd_data_o), 32'd0);
      check("rst_ackerr", 32'(ack_err_o), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         slave_cfg(tbl[i].cmd[2] & ~tbl[i].cmd[1], tbl[i].sbyte, tbl[i].sack, 1, tbl[i].cmd[0]);
         run_txn(tbl[i].cmd, tbl[i].wd, lat, ae1);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
         check($sformatf("vec%0d_ae_clr", i), 32'(ae1), 32'd0);
         check($sformatf("vec%0d_ackerr", i), 32'(ack_err_o), 32'(tbl[i].ae));
         check($sformatf("vec%0d_rd", i), 32'(rd_data_o), 32'(tbl[i].rd));
         check($sformatf("vec%0d_sda_out", i), 32'(sda_out_o), 32'd0);
         if (tbl[i].chk_bits) check_bits($sformatf("vec%0d", i), tbl[i].bbyte, tbl[i].b8);
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), 32'(done_o), 32'd0);
      end
      rd_model = 8'hC3;

      // Back-to-back bytes with req held and cmd stepped on each done
      slave_cfg(1'b0, 8'h00, 1'b1, 4, 1'b1);
      st0 = starts; sp0 = stops;
      @(negedge clk);
      req = 1'b1; cmd = b2b_cmd[0]; wr = b2b_wd[0];
      @(posedge clk);
      @(negedge clk);
      n = 1;
      while (!done_o && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("b2b0_lat", 32'(n), 32'(b2b_lat[0]));
      check("b2b0_scl_low", 32'(scl_o), 32'd0);
      for (int i = 1; i < 4; i++) begin
         cmd = b2b_cmd[i]; wr = b2b_wd[i];
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (n == 1) check($sformatf("b2b%0d_idle_scl", i), 32'(scl_o), 32'd0);
         end while (!done_o && n < 400);
         check($sformatf("b2b%0d_lat", i), 32'(n), 32'(b2b_lat[i]));
         if (i < 3) check($sformatf("b2b%0d_scl_low", i), 32'(scl_o), 32'd0);
      end
      check("b2b_ackerr", 32'(ack_err_o), 32'd0);
      req = 1'b0; cmd = 4'd0;
      repeat (4) @(negedge clk);
      check("b2b_starts", 32'(starts - st0), 32'd1);
      check("b2b_stops", 32'(stops - sp0), 32'd1);
      check("b2b_idle_scl", 32'(scl_o), 32'd1);
      check("b2b_idle_oe", 32'(sda_oe_o), 32'd0);

      // Empty command: immediate done, bus untouched
      slave_cfg(1'b0, 8'h00, 1'b0, 1, 1'b0);
      bc0 = bus_changes;
      run_txn(4'b0000, 8'hFF, lat, ae1);
      check("nop_lat", 32'(lat), 32'd1);
      repeat (3) @(negedge clk);
      check("nop_bus_quiet", 32'(bus_changes - bc0), 32'd0);

      // Randomized transactions against the byte-level reference model
      for (int k = 0; k < 16; k++) begin
         logic [3:0] c;
         logic [7:0] wd, sb;
         logic       ak, is_wr, is_rd;
         int         exp_lat;
         c  = 4'($urandom_range(0, 15));
         wd = 8'($urandom);
         sb = 8'($urandom);
         ak = 1'($urandom);
         is_wr = c[1];
         is_rd = c[2] & ~c[1];
         exp_lat = 1 + Q * (4 * int'(c[0]) + ((is_wr || is_rd) ? 36 : 0) + 4 * int'(c[3]));
         slave_cfg(is_rd, sb, ak, 1, c[0]);
         run_txn(c, wd, lat, ae1);
         if (is_rd) rd_model = sb;
         check($sformatf("rnd%0d_lat", k), 32'(lat), 32'(exp_lat));
         check($sformatf("rnd%0d_ackerr", k), 32'(ack_err_o), 32'(is_wr & ~ak));
         check($sformatf("rnd%0d_rd", k), 32'(rd_data_o), 32'(rd_model));
         if (is_wr) check_bits($sformatf("rnd%0d", k), wd, ~ak);
         if (is_rd) check_bits($sformatf("rnd%0d", k), sb, c[3]);
      end

      // Reset in the middle of a byte
      slave_cfg(1'b0, 8'h00, 1'b1, 1, 1'b1);
      @(negedge clk);
      req = 1'b1; cmd = 4'b0011; wr = 8'h00;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_scl", 32'(scl_o), 32'd1);
      check("midrst_oe", 32'(sda_oe_o), 32'd0);
      check("midrst_done", 32'(done_o), 32'd0);
      check("midrst_rd", 32'(rd_data_o), 32'd0);
      rst = 1'b0;
      slave_cfg(1'b0, 8'h00, 1'b1, 1, 1'b1);
      run_txn(4'b1011, 8'hA5, lat, ae1);
      check("postrst_lat", 32'(lat), 32'd89);
      check("postrst_ackerr", 32'(ack_err_o), 32'd0);
      check_bits("postrst", 8'hA5, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
